sev_seg_scan_driver: RTL

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It drives a single shared active-low segment bus (a..g plus decimal point) and scans the digits through active-low anode enables. Per-digit features: enable, decimal point, blink and leading-zero suppression. Sits between the ATM datapath (balance/PIN/menu nibbles) and the board display pins.

---
 rtl/sev_seg_scan_driver_pkg.sv | 27 ++
 rtl/sev_seg_glyph_rom.sv | 34 +++
 rtl/sev_seg_scan_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sev_seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyphs {a..g}
// and the supported digit-count range.
package sev_seg_scan_driver_pkg;

  localparam int N_DIGITS_MIN = 1;
  localparam int N_DIGITS_MAX = 8;

  localparam logic [6:0] GLYPH_0    = 7'b0000001;
  localparam logic [6:0] GLYPH_1    = 7'b1001111;
  localparam logic [6:0] GLYPH_2    = 7'b0010010;
  localparam logic [6:0] GLYPH_3    = 7'b0000110;
  localparam logic [6:0] GLYPH_4    = 7'b1001100;
  localparam logic [6:0] GLYPH_5    = 7'b0100100;
  localparam logic [6:0] GLYPH_6    = 7'b0100000;
  localparam logic [6:0] GLYPH_7    = 7'b0001111;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0000100;
  localparam logic [6:0] GLYPH_A    = 7'b0001000;
  localparam logic [6:0] GLYPH_B    = 7'b1100000;
  localparam logic [6:0] GLYPH_C    = 7'b0110001;
  localparam logic [6:0] GLYPH_D    = 7'b1000010;
  localparam logic [6:0] GLYPH_E    = 7'b0110000;
  localparam logic [6:0] GLYPH_F    = 7'b0111000;
  localparam logic [6:0] GLYPH_DASH = 7'b1111110;
  localparam logic [6:0] GLYPH_OFF  = 7'h7F;

endpackage

// File: rtl/sev_seg_glyph_rom.sv
// Combinational nibble-to-glyph decoder; with hex_en low, nibbles 10..15
// render as a dash so non-decimal data is visibly flagged.
module sev_seg_glyph_rom
  import sev_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_OFF;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_en ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph = hex_en ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph = hex_en ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph = hex_en ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph = hex_en ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph = hex_en ? GLYPH_F : GLYPH_DASH;
      default: glyph = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: per-frame input snapshot,
// blanking guard at the start of each digit slot, blink and leading-zero blanking.
module sev_seg_scan_driver
  import sev_seg_scan_driver_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_EN       = 1
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   an_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic                  frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic [4*N_DIGITS-1:0] sh_value;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_en;
  logic [N_DIGITS-1:0]   sh_blink;
  logic                  sh_lz;

  logic                  snap;
  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_blink;
  logic                  cur_supp;
  logic                  visible;
  logic [6:0]            glyph;

  assign snap       = (presc == '0) && (idx == '0);
  assign frame_tick = snap && !reset;

  // Scan counters, frame snapshot and blink phase. The blink counter runs
  // 1..BLINK_FRAMES so the phase flips at the tick that opens the next half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_value    <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      sh_lz       <= 1'b0;
    end else begin
      if (presc == PW'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (snap) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_en    <= digit_en;
        sh_blink <= blink_mask;
        sh_lz    <= lz_suppress;
        if (blink_cnt == BW'(BLINK_FRAMES)) begin
          blink_cnt   <= BW'(1);
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Walk from the most significant digit down; a digit stays blanked while
  // it and everything above it are zero. Digit 0 always shows.
  always_comb begin
    logic lz_run;
    lz_run = sh_lz;
    supp   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run  = lz_run && (sh_value[4*i +: 4] == 4'h0);
      supp[i] = (i > 0) && lz_run;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_value[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_en    = sh_en[i];
        cur_blink = sh_blink[i];
        cur_supp  = supp[i];
      end
    end
    visible = (presc >= PW'(BLANK_CYCLES)) && cur_en && !(blink_phase && cur_blink) && !cur_supp;
  end

  sev_seg_glyph_rom u_glyph_rom (
    .nibble (cur_nib),
    .hex_en (HEX_EN != 0),
    .glyph  (glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_out  <= '1;
      seg_out <= GLYPH_OFF;
      dp_out  <= 1'b1;
    end else if (visible) begin
      an_out  <= ~(N_DIGITS'(1) << idx);
      seg_out <= glyph;
      dp_out  <= ~cur_dp;
    end else begin
      an_out  <= '1;
      seg_out <= GLYPH_OFF;
      dp_out  <= 1'b1;
    end
  end

endmodule
